// File: rtl/bits_pkg.sv
// Shared types and field widths for the BITS stream parser.
// Field widths are in bits of the MSB-first transmission.
package bits_pkg;

    typedef enum logic [1:0] {
        HEADER,
        LIT_GROUP,
        OP_LEN,
        DONE
    } parse_state_e;

    localparam int HDR_W        = 6;
    localparam int GRP_W        = 5;
    localparam int TYPE_LITERAL = 4;
    localparam int LEN0_W       = 16;
    localparam int LEN1_W       = 12;
    localparam int MIN_PKT_W    = 11;

endpackage

// File: rtl/bits_stream_parser_if.sv
// Valid/ready beat interface carrying the MSB-first transmission into the parser.
interface bits_stream_parser_if #(
    parameter int IN_W = 16
) ();

    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/bits_shift_buffer.sv
// MSB-aligned append/consume bit buffer; bits above cnt are always zero.
// A consume and an append in the same cycle are applied in that order.
module bits_shift_buffer
    import bits_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int BUF_W = 64,
    parameter int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             resetB,
    input  logic             append_en,
    input  logic [IN_W-1:0]  append_data,
    input  logic             consume_en,
    input  logic [CNT_W-1:0] consume_w,
    input  logic             hold,
    output logic [HDR_W-1:0] peek,
    output logic [CNT_W-1:0] cnt,
    output logic             all_zero,
    output logic             ready
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] take_w;
    logic [CNT_W-1:0] rem_cnt;
    logic [BUF_W-1:0] rem_bits;
    logic [BUF_W-1:0] app_bits;

    // NOTE: every variable written here is given a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        take_w   = consume_en ? consume_w : '0;
        rem_bits = buf_q << take_w;
        rem_cnt  = cnt_q - take_w;
        app_bits = {append_data, {(BUF_W - IN_W){1'b0}}} >> rem_cnt;
        buf_d    = rem_bits;
        cnt_d    = rem_cnt;
        if (append_en) begin
            buf_d = rem_bits | app_bits;
            cnt_d = rem_cnt + CNT_W'(IN_W);
        end
    end

    // NOTE: the buffer is a plain register array, so it is cleared on reset;
    // the all-zero flag relies on no stale bits surviving an aborted parse.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign peek     = buf_q[BUF_W-1 -: HDR_W];
    assign cnt      = cnt_q;
    assign all_zero = ~|buf_q;
    assign ready    = !hold && (cnt_q <= CNT_W'(BUF_W - IN_W));

endmodule

// File: rtl/bits_stream_parser.sv
// BITS packet walker: header, literal-group and operator-length fields, one per clock,
// producing the running version sum, packet count and each literal value.
module bits_stream_parser
    import bits_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int BUF_W = 64,
    parameter int SUM_W = 16,
    parameter int LIT_W = 64
) (
    input  logic                 clk,
    input  logic                 resetB,
    bits_stream_parser_if.slave  in_bus,
    output logic [SUM_W-1:0]     version_sum,
    output logic [15:0]          packet_count,
    output logic                 lit_valid,
    output logic [LIT_W-1:0]     lit_value,
    output logic                 lit_overflow,
    output logic                 done,
    output logic                 error
);

    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] HDR_CNT  = CNT_W'(HDR_W);
    localparam logic [CNT_W-1:0] GRP_CNT  = CNT_W'(GRP_W);
    localparam logic [CNT_W-1:0] LEN0_CNT = CNT_W'(LEN0_W);
    localparam logic [CNT_W-1:0] LEN1_CNT = CNT_W'(LEN1_W);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PKT_W);

    if ((IN_W % 4) != 0 || IN_W < 4 || BUF_W < IN_W + 16) begin : g_bad_params
        $error("bits_stream_parser: IN_W must be a multiple of 4 and BUF_W >= IN_W + 16");
    end

    parse_state_e     state_q, state_d;
    logic             last_seen_q;
    logic [LIT_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic [SUM_W-1:0] sum_d;
    logic [15:0]      count_d;
    logic             lit_valid_d;
    logic [LIT_W-1:0] lit_value_d;
    logic             lit_ovf_d;
    logic             done_d;
    logic             error_d;

    logic             consume_en;
    logic [CNT_W-1:0] consume_w;
    logic [HDR_W-1:0] peek;
    logic [CNT_W-1:0] buf_cnt;
    logic             buf_zero;
    logic             buf_ready;
    logic             accept;

    logic [2:0]       hdr_version;
    logic [2:0]       hdr_type;
    logic             grp_more;
    logic [3:0]       grp_nibble;
    logic [CNT_W-1:0] len_w;

    assign accept          = in_bus.in_valid && buf_ready;
    assign in_bus.in_ready = buf_ready;

    // Fields are decoded from the head of the buffer; the operator length width
    // depends only on the I bit, which is the first buffered bit in OP_LEN.
    assign hdr_version = peek[HDR_W-1 -: 3];
    assign hdr_type    = peek[HDR_W-4 -: 3];
    assign grp_more    = peek[HDR_W-1];
    assign grp_nibble  = peek[HDR_W-2 -: 4];
    assign len_w       = peek[HDR_W-1] ? LEN1_CNT : LEN0_CNT;

    bits_shift_buffer #(
        .IN_W  (IN_W),
        .BUF_W (BUF_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk         (clk),
        .resetB      (resetB),
        .append_en   (accept),
        .append_data (in_bus.in_data),
        .consume_en  (consume_en),
        .consume_w   (consume_w),
        .hold        (last_seen_q || done),
        .peek        (peek),
        .cnt         (buf_cnt),
        .all_zero    (buf_zero),
        .ready       (buf_ready)
    );

    always_comb begin
        state_d     = state_q;
        consume_en  = 1'b0;
        consume_w   = '0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        sum_d       = version_sum;
        count_d     = packet_count;
        lit_valid_d = 1'b0;
        lit_value_d = lit_value;
        lit_ovf_d   = lit_overflow;
        done_d      = done;
        error_d     = error;

        unique case (state_q)
            HEADER: begin
                // Trailing padding after the last packet ends the parse cleanly.
                if (last_seen_q && (buf_cnt < MIN_CNT || buf_zero)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (buf_cnt >= HDR_CNT) begin
                    consume_en = 1'b1;
                    consume_w  = HDR_CNT;
                    sum_d      = version_sum + SUM_W'(hdr_version);
                    count_d    = packet_count + 16'd1;
                    if (hdr_type == 3'(TYPE_LITERAL)) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = LIT_GROUP;
                    end else begin
                        state_d = OP_LEN;
                    end
                end
            end

            LIT_GROUP: begin
                if (buf_cnt >= GRP_CNT) begin
                    consume_en = 1'b1;
                    consume_w  = GRP_CNT;
                    acc_d      = {acc_q[LIT_W-5:0], grp_nibble};
                    if (|acc_q[LIT_W-1 -: 4]) begin
                        ovf_d = 1'b1;
                    end
                    if (!grp_more) begin
                        lit_valid_d = 1'b1;
                        lit_value_d = acc_d;
                        lit_ovf_d   = ovf_d;
                        state_d     = HEADER;
                    end
                end else if (last_seen_q) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            OP_LEN: begin
                // Length/count values are dropped; nesting is not tracked.
                if (buf_cnt >= len_w) begin
                    consume_en = 1'b1;
                    consume_w  = len_w;
                    state_d    = HEADER;
                end else if (last_seen_q) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = HEADER;
            end
        endcase
    end

    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state_q      <= HEADER;
            last_seen_q  <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            version_sum  <= '0;
            packet_count <= '0;
            lit_valid    <= 1'b0;
            lit_value    <= '0;
            lit_overflow <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            version_sum  <= sum_d;
            packet_count <= count_d;
            lit_valid    <= lit_valid_d;
            lit_value    <= lit_value_d;
            lit_overflow <= lit_ovf_d;
            done         <= done_d;
            error        <= error_d;
            if (accept && in_bus.in_last) begin
                last_seen_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bits_stream_parser.md
# bits_stream_parser

Parametrised BITS packet parser for the day-16 datapath. Consumes the hexadecimal transmission as an MSB-first bit stream over a valid/ready handshake, walks every packet header, literal group and operator length field, and produces the running version sum, a packet count and each decoded literal value. It sits between the instruction-memory reader and the expression evaluator, replacing the fixed-width header path of the earlier FSM.

## Interface
- IN_W, 16: bits per input beat; multiple of 4, ≥ 4.
- BUF_W, 64: shift-buffer depth in bits; must be ≥ IN_W + 16.
- SUM_W, 16: width of version_sum.
- LIT_W, 64: width of lit_value.
- clk  in  1  system clock; the block has one clock.
- resetB  in  1  reset, asynchronous, active-low.
- in_data  in  IN_W  next stream bits; bit IN_W-1 is first on the wire.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final beat; qualified by in_valid.
- in_ready  out  1  block can accept a beat this cycle.
- version_sum  out  SUM_W  sum of all packet versions, wraps modulo 2^SUM_W.
- packet_count  out  16  headers parsed, wraps.
- lit_valid  out  1  one-cycle pulse: a literal has completed.
- lit_value  out  LIT_W  decoded literal; held until the next pulse.
- lit_overflow  out  1  qualified by lit_valid: the literal exceeded LIT_W bits.
- done  out  1  stream fully parsed; sticky until reset.
- error  out  1  stream truncated inside a field; sticky, asserted with done.

## Operation
- Buffer holds cnt valid bits, MSB-aligned. Bits above cnt are kept zero.
- Beat accepted when in_valid && in_ready. Its bits are appended after the bits that remain after this cycle's consume. Accepting a beat with in_last sets last_seen.
- in_ready = !last_seen && !done && (cnt ≤ BUF_W − IN_W), computed from registered state.
- Each cycle, at most one field is consumed, and only when cnt ≥ the field width. Otherwise the FSM stalls.
- HEADER (6 bits):
  - If last_seen and (cnt < 11 or all buffered bits are zero): go to DONE with error = 0.
  - Otherwise: version_sum += version[2:0] and packet_count += 1.
  - If type == 4: clear the accumulator and go to LIT_GROUP. Else go to OP_LEN.
- LIT_GROUP (5 bits):
  - acc = {acc, nibble}.
  - If any of the top 4 bits of acc are nonzero before the shift, set the sticky ovf bit.
  - If prefix == 0: pulse lit_valid with lit_value = acc (low LIT_W bits), lit_overflow = ovf, then go to HEADER.
- OP_LEN: peek the first bit (I).
  - I = 0: consume 16 bits.
  - I = 1: consume 12 bits.
  - Then go to HEADER. Length and count values are discarded; nesting is not tracked.
- Truncation: in LIT_GROUP or OP_LEN, if last_seen and cnt < the required width, set error and go to DONE.
- DONE: no further consumption, in_ready = 0, all outputs hold.

## Timing
- Reset: all registers cleared, state HEADER, cnt = 0, every output 0 except in_ready = 1 (including while resetB is low).
- Header effects (version_sum, packet_count) are visible the cycle after the consuming edge.
- lit_valid is high for exactly the one cycle after the edge that consumes the final group.
- done/error rise the cycle after the terminating condition is evaluated.
- Throughput: one field per clock. An accept and a consume in the same cycle are legal and lossless.
- Reset mid-stream aborts the current parse immediately. Partially buffered bits are discarded.

## Structure
- Package bits_pkg holds:
  - the state enum (HEADER, LIT_GROUP, OP_LEN, DONE);
  - constants HDR_W = 6, GRP_W = 5, TYPE_LITERAL = 4, LEN0_W = 16, LEN1_W = 12, MIN_PKT_W = 11.
- Sub-module bits_shift_buffer: BUF_W-bit append/consume buffer with cnt, a zero-remainder flag and the in_ready computation.
- Parser FSM and accumulators live in the top level.

## Test plan
- IN_W = 8, beats D2, FE, 28(last) -> lit_valid once with lit_value = 2021, version_sum = 6, packet_count = 1, done = 1, error = 0.
- 38006F45291200 -> literals 10 then 20, version_sum = 9, packet_count = 3, done = 1.
- The AoC examples 8A004A801A8002F478 / 620080001611562C8802118E34 / C0015000016115A2E0802F182340 / A0016C880162017C3686B18A3D4780 -> version_sum 16 / 12 / 23 / 31, error = 0.
- BUF_W = 32, IN_W = 16, random in_valid gaps -> results identical to the unstalled run. Check in_ready deasserts whenever cnt > 16, and that no beat is lost.
- IN_W = 8, beats D2, FE(last) -> version_sum = 6, packet_count = 1, no lit_valid, error = 1, done = 1.
- Drive resetB low during the second beat of D2FE28 -> all outputs 0 immediately. After release, resending the stream gives the first scenario's result.
